// File: rtl/pipe_ctrl_pkg.sv
// pipe_ctrl_pkg: stall-vector bit indices and encodings, stop flags and controller state codes.
package pipe_ctrl_pkg;

    localparam int STALL_W     = 6;
    localparam int STALL_PC    = 0;
    localparam int STALL_IFID  = 1;
    localparam int STALL_IDEX  = 2;
    localparam int STALL_EXMEM = 3;
    localparam int STALL_MEMWB = 4;
    localparam int STALL_WB    = 5;

    // A stalled stage also holds every stage upstream of it.
    localparam logic [STALL_W-1:0] STALL_NONE = 6'b000000;
    localparam logic [STALL_W-1:0] STALL_IF   = 6'b000011;
    localparam logic [STALL_W-1:0] STALL_ID   = 6'b000111;
    localparam logic [STALL_W-1:0] STALL_EX   = 6'b001111;
    localparam logic [STALL_W-1:0] STALL_MEM  = 6'b011111;

    localparam logic STOP    = 1'b1;
    localparam logic NO_STOP = 1'b0;

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_FLUSH = 1'b1
    } state_e;

endpackage

// File: rtl/pipe_ctrl_stall_watchdog.sv
// pipe_ctrl_stall_watchdog: counts consecutive stalled cycles and raises a sticky deadlock flag.
//   clk_i, rst_i : clock, asynchronous active-high reset
//   stalled_i    : PC stage held this cycle
//   clear_i      : force the run length back to zero (pipeline is flushing)
//   timeout_o    : sticky, set the edge after the run length reaches STALL_TIMEOUT
module pipe_ctrl_stall_watchdog import pipe_ctrl_pkg::*; #(
    parameter int STALL_TIMEOUT = 1024
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic stalled_i,
    input  logic clear_i,
    output logic timeout_o
);

    logic [15:0] cnt_q, cnt_d;
    logic        to_q, to_d;

    always_comb begin
        cnt_d = (stalled_i == STOP && !clear_i) ? (&cnt_q ? cnt_q : cnt_q + 16'd1) : 16'd0;
        to_d  = to_q | (cnt_q >= 16'(STALL_TIMEOUT));
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= '0;
            to_q  <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            to_q  <= to_d;
        end
    end

    assign timeout_o = to_q;

endmodule

// File: rtl/pipe_ctrl.sv
// pipe_ctrl: pipeline sequencer merging stall requests, redirecting on trap/mret/irq and watching for deadlock.
//   clk_i, rst_i        : clock, asynchronous active-high reset
//   stallreq_*_i        : per-stage stall requests (if, id, ex, mem)
//   trap_req_i, mret_i  : MEM-stage exception / mret retire
//   irq_i               : masked level interrupt
//   mtvec_i, mepc_i     : redirect targets
//   stall_o             : per-stage hold vector
//   flush_o             : squash IF/ID, ID/EX, EX/MEM
//   new_pc_valid_o/new_pc_o : fetch redirect pulse and target
//   irq_taken_o         : interrupt accepted this cycle
//   stall_timeout_o     : sticky deadlock flag
module pipe_ctrl import pipe_ctrl_pkg::*; #(
    parameter int FLUSH_CYCLES  = 1,
    parameter int STALL_TIMEOUT = 1024,
    parameter int ADDR_W        = 32
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                stallreq_if_i,
    input  logic                stallreq_id_i,
    input  logic                stallreq_ex_i,
    input  logic                stallreq_mem_i,
    input  logic                trap_req_i,
    input  logic                mret_i,
    input  logic                irq_i,
    input  logic [ADDR_W-1:0]   mtvec_i,
    input  logic [ADDR_W-1:0]   mepc_i,
    output logic [STALL_W-1:0]  stall_o,
    output logic                flush_o,
    output logic                new_pc_valid_o,
    output logic [ADDR_W-1:0]   new_pc_o,
    output logic                irq_taken_o,
    output logic                stall_timeout_o
);

    state_e              state_q, state_d;
    logic [2:0]          fcnt_q, fcnt_d;
    logic [ADDR_W-1:0]   pc_q, pc_d;
    logic [STALL_W-1:0]  run_stall;
    logic                run, last, irq_take, redirect;

    always_comb begin
        run_stall = stallreq_mem_i ? STALL_MEM :
                    stallreq_ex_i  ? STALL_EX  :
                    stallreq_id_i  ? STALL_ID  :
                    stallreq_if_i  ? STALL_IF  : STALL_NONE;
        run      = state_q == ST_RUN;
        last     = fcnt_q == 3'(FLUSH_CYCLES - 1);
        stall_o  = run ? run_stall : STALL_NONE;
        // An interrupt is only taken on a fully free-flowing cycle so mepc is well defined.
        irq_take = run && !trap_req_i && !mret_i && irq_i && run_stall == STALL_NONE;
        redirect = run && (trap_req_i || mret_i || irq_take);
        state_d  = redirect ? ST_FLUSH : (!run && last) ? ST_RUN : state_q;
        fcnt_d   = (run || last) ? 3'd0 : fcnt_q + 3'd1;
        pc_d     = !redirect ? pc_q : (mret_i && !trap_req_i) ? mepc_i : mtvec_i;
        flush_o        = !run;
        new_pc_valid_o = !run && fcnt_q == 3'd0;
        irq_taken_o    = irq_take;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= ST_RUN;
            fcnt_q  <= '0;
            pc_q    <= '0;
        end else begin
            state_q <= state_d;
            fcnt_q  <= fcnt_d;
            pc_q    <= pc_d;
        end
    end

    assign new_pc_o = pc_q;

    pipe_ctrl_stall_watchdog #(
        .STALL_TIMEOUT (STALL_TIMEOUT)
    ) u_wd (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .stalled_i (stall_o[STALL_PC]),
        .clear_i   (!run),
        .timeout_o (stall_timeout_o)
    );

endmodule

// File: tb/tb_pipe_ctrl.sv
// tb_pipe_ctrl: directed scenarios plus randomized run against a cycle-level behavioural model.
module tb_pipe_ctrl;

    localparam int FC = 2;
    localparam int TO = 8;
    localparam int AW = 32;

    logic          clk_i = 1'b0;
    logic          rst_i = 1'b1;
    logic          sif, sid, sex, smem, trap, mret, irq;
    logic [AW-1:0] mtvec, mepc;
    logic [5:0]    stall_o;
    logic          flush_o, new_pc_valid_o, irq_taken_o, stall_timeout_o;
    logic [AW-1:0] new_pc_o;

    int tests = 0;
    int fails = 0;

    int          m_left;
    int          m_run;
    bit          m_to;
    logic [31:0] m_pc;

    pipe_ctrl #(.FLUSH_CYCLES(FC), .STALL_TIMEOUT(TO), .ADDR_W(AW)) dut (
        .clk_i           (clk_i),
        .rst_i           (rst_i),
        .stallreq_if_i   (sif),
        .stallreq_id_i   (sid),
        .stallreq_ex_i   (sex),
        .stallreq_mem_i  (smem),
        .trap_req_i      (trap),
        .mret_i          (mret),
        .irq_i           (irq),
        .mtvec_i         (mtvec),
        .mepc_i          (mepc),
        .stall_o         (stall_o),
        .flush_o         (flush_o),
        .new_pc_valid_o  (new_pc_valid_o),
        .new_pc_o        (new_pc_o),
        .irq_taken_o     (irq_taken_o),
        .stall_timeout_o (stall_timeout_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic idle();
        {sif, sid, sex, smem, trap, mret, irq} = '0;
        mtvec = '0;
        mepc  = '0;
    endtask

    task automatic cyc();
        @(posedge clk_i);
        #1;
    endtask

    task automatic do_reset();
        rst_i = 1'b1;
        idle();
        cyc();
        cyc();
        rst_i = 1'b0;
        m_left = 0;
        m_run  = 0;
        m_to   = 1'b0;
        m_pc   = '0;
    endtask

    task automatic test_reset();
        do_reset();
        @(negedge clk_i);
        tests++;
        if ({stall_o, flush_o, new_pc_valid_o, new_pc_o, irq_taken_o, stall_timeout_o} !== '0) begin
            fails++;
            $display("FAIL reset_idle: stall=%b flush=%b npv=%b pc=%h irq=%b to=%b, all zero required",
                     stall_o, flush_o, new_pc_valid_o, new_pc_o, irq_taken_o, stall_timeout_o);
        end
        cyc();
        mtvec = 32'h0000_0100;
        trap  = 1'b1;
        cyc();
        trap = 1'b0;
        @(negedge clk_i);
        tests++;
        if (flush_o !== 1'b1) begin
            fails++;
            $display("FAIL reset_pre_flush: flush=%b, 1 required", flush_o);
        end
        rst_i = 1'b1;
        #1;
        tests++;
        if ({flush_o, new_pc_valid_o, new_pc_o} !== '0) begin
            fails++;
            $display("FAIL reset_async: flush=%b npv=%b pc=%h, all zero required", flush_o, new_pc_valid_o, new_pc_o);
        end
        cyc();
        rst_i = 1'b0;
        sid   = 1'b1;
        @(negedge clk_i);
        tests++;
        if ({flush_o, stall_o} !== {1'b0, 6'b000111}) begin
            fails++;
            $display("FAIL reset_run: flush=%b stall=%b, flush=0 stall=000111 required", flush_o, stall_o);
        end
        idle();
        cyc();
    endtask

    task automatic test_stall_merge();
        do_reset();
        sid = 1'b1;
        sex = 1'b1;
        @(negedge clk_i);
        tests++;
        if (stall_o !== 6'b001111) begin
            fails++;
            $display("FAIL stall_id_ex: got %b, 001111 required", stall_o);
        end
        sex = 1'b0;
        #1;
        tests++;
        if (stall_o !== 6'b000111) begin
            fails++;
            $display("FAIL stall_id: got %b, 000111 required", stall_o);
        end
        smem = 1'b1;
        #1;
        tests++;
        if (stall_o !== 6'b011111) begin
            fails++;
            $display("FAIL stall_mem: got %b, 011111 required", stall_o);
        end
        idle();
        sif = 1'b1;
        #1;
        tests++;
        if (stall_o !== 6'b000011) begin
            fails++;
            $display("FAIL stall_if: got %b, 000011 required", stall_o);
        end
        idle();
        cyc();
    endtask

    task automatic test_trap();
        do_reset();
        mtvec = 32'h0000_0100;
        trap  = 1'b1;
        smem  = 1'b1;
        cyc();
        trap = 1'b0;
        @(negedge clk_i);
        tests++;
        if ({flush_o, new_pc_valid_o, new_pc_o, stall_o} !== {1'b1, 1'b1, 32'h100, 6'b0}) begin
            fails++;
            $display("FAIL trap_first: flush=%b npv=%b pc=%h stall=%b, 1 1 00000100 000000 required",
                     flush_o, new_pc_valid_o, new_pc_o, stall_o);
        end
        cyc();
        @(negedge clk_i);
        tests++;
        if ({flush_o, new_pc_valid_o} !== 2'b10) begin
            fails++;
            $display("FAIL trap_second: flush=%b npv=%b, 1 0 required", flush_o, new_pc_valid_o);
        end
        cyc();
        @(negedge clk_i);
        tests++;
        if ({flush_o, new_pc_valid_o, new_pc_o, stall_o} !== {1'b0, 1'b0, 32'h100, 6'b011111}) begin
            fails++;
            $display("FAIL trap_done: flush=%b npv=%b pc=%h stall=%b, 0 0 00000100 011111 required",
                     flush_o, new_pc_valid_o, new_pc_o, stall_o);
        end
        idle();
        cyc();
    endtask

    task automatic test_trap_mret();
        do_reset();
        mtvec = 32'h0000_0100;
        mepc  = 32'h0000_0200;
        trap  = 1'b1;
        mret  = 1'b1;
        cyc();
        trap = 1'b0;
        mret = 1'b0;
        @(negedge clk_i);
        tests++;
        if ({new_pc_valid_o, new_pc_o} !== {1'b1, 32'h100}) begin
            fails++;
            $display("FAIL trap_over_mret: npv=%b pc=%h, 1 00000100 required", new_pc_valid_o, new_pc_o);
        end
        mtvec = 32'h0000_0300;
        trap  = 1'b1;
        cyc();
        @(negedge clk_i);
        tests++;
        if ({flush_o, new_pc_valid_o} !== 2'b10) begin
            fails++;
            $display("FAIL trap_in_flush: flush=%b npv=%b, 1 0 required", flush_o, new_pc_valid_o);
        end
        cyc();
        trap = 1'b0;
        @(negedge clk_i);
        tests++;
        if ({flush_o, new_pc_valid_o, new_pc_o} !== {1'b0, 1'b0, 32'h100}) begin
            fails++;
            $display("FAIL trap_ignored: flush=%b npv=%b pc=%h, 0 0 00000100 required",
                     flush_o, new_pc_valid_o, new_pc_o);
        end
        mret = 1'b1;
        cyc();
        mret = 1'b0;
        @(negedge clk_i);
        tests++;
        if ({new_pc_valid_o, new_pc_o} !== {1'b1, 32'h200}) begin
            fails++;
            $display("FAIL mret_target: npv=%b pc=%h, 1 00000200 required", new_pc_valid_o, new_pc_o);
        end
        idle();
        cyc();
        cyc();
    endtask

    task automatic test_irq();
        do_reset();
        mtvec = 32'h0000_0180;
        sex   = 1'b1;
        irq   = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk_i);
            tests++;
            if (irq_taken_o !== 1'b0) begin
                fails++;
                $display("FAIL irq_blocked[%0d]: irq_taken=%b, 0 required", i, irq_taken_o);
            end
            cyc();
        end
        sex = 1'b0;
        @(negedge clk_i);
        tests++;
        if (irq_taken_o !== 1'b1) begin
            fails++;
            $display("FAIL irq_taken: irq_taken=%b, 1 required", irq_taken_o);
        end
        cyc();
        @(negedge clk_i);
        tests++;
        if ({irq_taken_o, flush_o, new_pc_valid_o, new_pc_o} !== {1'b0, 1'b1, 1'b1, 32'h180}) begin
            fails++;
            $display("FAIL irq_flush: irq_taken=%b flush=%b npv=%b pc=%h, 0 1 1 00000180 required",
                     irq_taken_o, flush_o, new_pc_valid_o, new_pc_o);
        end
        idle();
        cyc();
        cyc();
    endtask

    task automatic test_watchdog();
        do_reset();
        smem = 1'b1;
        for (int i = 1; i <= TO + 1; i++) begin
            cyc();
            @(negedge clk_i);
            tests++;
            if (stall_timeout_o !== (i == TO + 1)) begin
                fails++;
                $display("FAIL wd_rise[%0d]: timeout=%b, %b required", i, stall_timeout_o, i == TO + 1);
            end
        end
        smem = 1'b0;
        cyc();
        cyc();
        @(negedge clk_i);
        tests++;
        if (stall_timeout_o !== 1'b1) begin
            fails++;
            $display("FAIL wd_sticky: timeout=%b, 1 required", stall_timeout_o);
        end
        do_reset();
        smem = 1'b1;
        for (int i = 0; i < TO - 1; i++) cyc();
        smem = 1'b0;
        cyc();
        smem = 1'b1;
        for (int i = 0; i < TO - 1; i++) cyc();
        smem = 1'b0;
        cyc();
        cyc();
        @(negedge clk_i);
        tests++;
        if (stall_timeout_o !== 1'b0) begin
            fails++;
            $display("FAIL wd_short: timeout=%b, 0 required", stall_timeout_o);
        end
        idle();
    endtask

    task automatic test_random(input int n, input int sp);
        logic [5:0] e_stall;
        logic       busy, e_irq;
        do_reset();
        for (int c = 0; c < n; c++) begin
            sif   = ($urandom_range(0, sp) == 0);
            sid   = ($urandom_range(0, sp) == 0);
            sex   = ($urandom_range(0, sp) == 0);
            smem  = ($urandom_range(0, sp) == 0);
            trap  = ($urandom_range(0, 15) == 0);
            mret  = ($urandom_range(0, 15) == 0);
            irq   = ($urandom_range(0, 5) == 0);
            mtvec = $urandom;
            mepc  = $urandom;
            @(negedge clk_i);
            busy    = m_left > 0;
            e_stall = busy ? 6'b0 : smem ? 6'b011111 : sex ? 6'b001111 : sid ? 6'b000111 : sif ? 6'b000011 : 6'b0;
            e_irq   = !busy && !trap && !mret && irq && e_stall == 6'b0;
            tests++;
            if ({stall_o, flush_o, new_pc_valid_o, new_pc_o, irq_taken_o, stall_timeout_o} !==
                {e_stall, busy, busy && m_left == FC, m_pc, e_irq, m_to}) begin
                fails++;
                $display("FAIL random[%0d]: got stall=%b fl=%b npv=%b pc=%h irq=%b to=%b, need stall=%b fl=%b npv=%b pc=%h irq=%b to=%b",
                         c, stall_o, flush_o, new_pc_valid_o, new_pc_o, irq_taken_o, stall_timeout_o,
                         e_stall, busy, busy && m_left == FC, m_pc, e_irq, m_to);
            end
            @(posedge clk_i);
            m_to  = m_to | (m_run >= TO);
            m_run = e_stall[0] ? ((m_run < 65535) ? m_run + 1 : m_run) : 0;
            if (busy) m_left--;
            else if (trap || mret || e_irq) begin
                m_left = FC;
                m_pc   = trap ? mtvec : mret ? mepc : mtvec;
            end
            #1;
        end
        idle();
    endtask

    initial begin
        idle();
        test_reset();
        test_stall_merge();
        test_trap();
        test_trap_mret();
        test_irq();
        test_watchdog();
        test_random(400, 7);
        test_random(400, 2);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/pipe_ctrl.md
Name: pipe_ctrl

Overview:
- Central pipeline sequencer for the 5-stage core.
- Merges per-stage stall requests into the 6-bit stall vector consumed by every pipeline register: bit0 PC, bit1 IF/ID, bit2 ID/EX, bit3 EX/MEM, bit4 MEM/WB, bit5 WB.
- Sequences trap, interrupt and mret redirection as a timed flush with a new fetch PC.
- Runs a stall watchdog that flags pipeline deadlock.

Parameters:
- FLUSH_CYCLES, 1, number of cycles flush_o stays high per redirect (1..7).
- STALL_TIMEOUT, 1024, consecutive stalled cycles before stall_timeout_o sets (2..65535).
- ADDR_W, 32, PC width.

Ports:
- clk_i  in  1  core clock; all state updates on the rising edge.
- rst_i  in  1  reset, asynchronous, active-high.
- stallreq_if_i  in  1  fetch is waiting on instruction memory.
- stallreq_id_i  in  1  decode hazard (load-use).
- stallreq_ex_i  in  1  multi-cycle EX operation (mul/div).
- stallreq_mem_i  in  1  data memory is waiting.
- trap_req_i  in  1  synchronous exception from the MEM stage.
- mret_i  in  1  mret retiring in the MEM stage.
- irq_i  in  1  level interrupt, already masked by the CSR unit.
- mtvec_i  in  ADDR_W  trap vector base.
- mepc_i  in  ADDR_W  return address for mret.
- stall_o  out  6  stall vector; 1 = hold that stage.
- flush_o  out  1  squash IF/ID, ID/EX and EX/MEM.
- new_pc_valid_o  out  1  single-cycle pulse: fetch loads new_pc_o.
- new_pc_o  out  ADDR_W  redirect target.
- irq_taken_o  out  1  single-cycle pulse: interrupt accepted; CSR unit saves mepc and cause.
- stall_timeout_o  out  1  sticky deadlock flag.

Behaviour:
- Reset values:
  - stall_o = 0, flush_o = 0, new_pc_valid_o = 0, new_pc_o = 0, irq_taken_o = 0, stall_timeout_o = 0.
  - FSM = RUN, flush counter = 0, watchdog counter = 0.
  - Asserting reset mid-flush abandons the flush immediately.
- FSM states: RUN and FLUSH.
- Stall vector in RUN (combinational, priority highest first):
  - mem → 011111
  - ex → 001111
  - id → 000111
  - if → 000011
  - none → 000000
  - Bit5 is never asserted.
- In FLUSH: stall_o = 000000.
- RUN to FLUSH triggers, evaluated at the rising edge, priority trap_req_i > mret_i > irq_i:
  - trap_req_i: target = mtvec_i. Trap wins even while stallreq_mem_i is high.
  - mret_i: target = mepc_i.
  - irq_i: taken only when stall_o == 0 that cycle. The controller pulses irq_taken_o in that same cycle. Target = mtvec_i.
- Request sampled at edge N, FLUSH entered:
  - Cycle N+1: flush_o = 1, new_pc_valid_o = 1, new_pc_o = latched target.
  - flush_o stays high for FLUSH_CYCLES cycles; new_pc_valid_o is high only in the first of them.
  - new_pc_o holds the target until the next redirect.
  - Return to RUN after the last flush cycle.
- In FLUSH, trap_req_i, mret_i and irq_i are ignored; they come from squashed instructions.
- Simultaneous trap_req_i and mret_i: trap wins; mret is dropped.
- Watchdog (16-bit saturating counter):
  - Increments on every cycle with stall_o[0] == 1.
  - Clears on any cycle with stall_o[0] == 0, and in FLUSH.
  - When the counter reaches STALL_TIMEOUT, stall_timeout_o goes high on the next edge and stays high until reset.
- Flush counter width: 3 bits.

Decomposition:
- Shared defines package (defines.v) holds:
  - stall-vector bit indices;
  - STALL_NONE / STALL_IF / STALL_ID / STALL_EX / STALL_MEM encodings;
  - FSM state codes;
  - Stop / NoStop macros.
- One natural sub-module: stall_watchdog (counter, saturation, sticky flag). The FSM and stall merge stay in pipe_ctrl.

Test Plan:
1. Reset applied, then idle inputs → all outputs 0. Assert rst_i mid-FLUSH → flush_o drops asynchronously; FSM = RUN.
2. stallreq_id_i and stallreq_ex_i high together → stall_o = 001111. Drop ex → 000111 in the same cycle. Add mem → 011111.
3. trap_req_i for 1 cycle with mtvec_i = 0x0000_0100, FLUSH_CYCLES = 2 → next cycle flush_o = 1, new_pc_valid_o = 1, new_pc_o = 0x100. Following cycle flush_o = 1, new_pc_valid_o = 0. Then RUN.
4. trap_req_i and mret_i together, mepc_i = 0x200 → new_pc_o = 0x100 (trap wins). A trap_req_i pulse during FLUSH → no second new_pc_valid_o.
5. irq_i high while stallreq_ex_i is high for 3 cycles → no irq_taken_o. Ex drops → irq_taken_o pulses that cycle, then flush with new_pc_o = mtvec_i.
6. STALL_TIMEOUT = 8, stallreq_mem_i held high → stall_timeout_o rises 9 cycles after the stall begins and stays high after the stall is released. A 7-cycle stall followed by 1 free cycle → no timeout.
